// File: rtl/seq_multiplier_n_pkg.sv
// Shared types for the sequential shift-add multiplier: FSM state encoding
// and the legal operand-width range.
package seq_multiplier_n_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    function automatic bit width_legal(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/seq_multiplier_n_adder.sv
// WIDTH-bit ripple adder with carry out; used for the acc_hi + A step.
module adder_n #(
    parameter int WIDTH = 8
) (
    output logic             cout,
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier, one add/shift step per clock, with
// start/done handshake and optional two's-complement operands.
module seq_multiplier_n
    import seq_multiplier_n_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    if (!width_legal(WIDTH)) begin : g_width_check
        $error("seq_multiplier_n: WIDTH must be in 2..32");
    end

    state_t               state, next_state;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;
    logic                 neg;
    logic                 cout;
    logic [WIDTH-1:0]     sum;

    // In signed mode the datapath works on magnitudes; -2^(W-1) maps to 2^(W-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic sm);
        return (sm && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    adder_n #(.WIDTH(WIDTH)) u_adder (
        .cout (cout),
        .sum  (sum),
        .a    (acc[2*WIDTH-1:WIDTH]),
        .b    (a_q)
    );

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (count == LAST_STEP) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (areset) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            count   <= '0;
            neg     <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_q   <= magnitude(multiplicand, signed_mode);
                    b_q   <= magnitude(multiplier, signed_mode);
                    neg   <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    acc   <= '0;
                    count <= '0;
                end
                RUN: begin
                    // Shift {carry, sum, acc_lo} right by one; the dropped bit is acc[0].
                    if (b_q[0]) acc <= {cout, sum, acc[WIDTH-1:1]};
                    else        acc <= {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
                    b_q   <= b_q >> 1;
                    count <= count + 1'b1;
                end
                FIX: begin
                    product <= neg ? (~acc + 1'b1) : acc;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Scoreboard bench for seq_multiplier_n at WIDTH=8 and WIDTH=16: drivers push
// expected products, negedge monitors pop and compare on every done pulse.
module tb_seq_multiplier_n;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8, prev8;
    logic        start16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] prod16, prev16;
    logic        rst_q;

    int total = 0;
    int bad   = 0;
    logic [15:0] q8[$];
    logic [31:0] q16[$];

    seq_multiplier_n #(.WIDTH(8)) dut8 (
        .clk(clk), .areset(areset), .start(start8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    seq_multiplier_n #(.WIDTH(16)) dut16 (
        .clk(clk), .areset(areset), .start(start16), .signed_mode(sm16),
        .multiplicand(a16), .multiplier(b16),
        .busy(busy16), .done(done16), .product(prod16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer multiply of the operands' numeric values.
    function automatic logic [63:0] ref_mul(input int w, input bit sm,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, mask;
        ea = 64'(a);
        eb = 64'(b);
        if (sm && a[w-1]) ea = ea - (64'd1 << w);
        if (sm && b[w-1]) eb = eb - (64'd1 << w);
        mask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        return (ea * eb) & mask;
    endfunction

    always @(posedge clk) rst_q <= areset;

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) check("done8_unexpected", 1, 0);
            else check("product8", prod8, q8.pop_front());
        end else if (rst_q === 1'b0) begin
            check("product8_hold", prod8, prev8);
        end
        prev8 = prod8;
    end

    always @(negedge clk) begin
        if (done16) begin
            if (q16.size() == 0) check("done16_unexpected", 1, 0);
            else check("product16", prod16, q16.pop_front());
        end else if (rst_q === 1'b0) begin
            check("product16_hold", prod16, prev16);
        end
        prev16 = prod16;
    end

    // Called at a negedge with the DUT idle; returns one negedge later.
    task automatic issue8(input bit sm, input logic [7:0] a, input logic [7:0] b);
        start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        q8.push_back(16'(ref_mul(8, sm, 32'(a), 32'(b))));
        @(negedge clk);
        start8 = 1'b0; sm8 = $urandom; a8 = $urandom; b8 = $urandom;
    endtask

    task automatic issue16(input bit sm, input logic [15:0] a, input logic [15:0] b);
        start16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
        q16.push_back(32'(ref_mul(16, sm, 32'(a), 32'(b))));
        @(negedge clk);
        start16 = 1'b0; sm16 = $urandom; a16 = $urandom; b16 = $urandom;
    endtask

    // Waits for done; busy must stay high for the remaining RUN+FIX cycles.
    task automatic wait_done8(input int exp_busy, output int cycles);
        int busyc = 0;
        cycles = 0;
        while (!done8 && cycles < 60) begin
            if (busy8) busyc++;
            @(negedge clk);
            cycles++;
        end
        if (!done8) check("timeout8", 0, 1);
        else check("busy8_cycles", 64'(busyc), 64'(exp_busy));
    endtask

    task automatic wait_done16(input int exp_busy, output int cycles);
        int busyc = 0;
        cycles = 0;
        while (!done16 && cycles < 60) begin
            if (busy16) busyc++;
            @(negedge clk);
            cycles++;
        end
        if (!done16) check("timeout16", 0, 1);
        else check("busy16_cycles", 64'(busyc), 64'(exp_busy));
    endtask

    function automatic logic [15:0] pick(input int w);
        logic [15:0] top, all;
        all = (w == 8) ? 16'h00FF : 16'hFFFF;
        top = (w == 8) ? 16'h0080 : 16'h8000;
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return top;
            2:       return top - 16'd1;
            3:       return all;
            default: return 16'($urandom) & all;
        endcase
    endfunction

    initial begin
        int n;
        areset = 1'b1;
        start8 = 1'b0;  sm8 = 1'b0;  a8 = '0;  b8 = '0;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        check("reset_busy8", busy8, 0);
        check("reset_done8", done8, 0);
        check("reset_product8", prod8, 0);
        check("reset_busy16", busy16, 0);
        check("reset_product16", prod16, 0);
        areset = 1'b0;
        @(negedge clk);

        issue8(1'b0, 8'hFF, 8'hFF);
        wait_done8(9, n);
        // Back-to-back: start issued in the done cycle.
        issue8(1'b0, 8'h12, 8'h34);
        wait_done8(9, n);
        check("b2b_spacing8", 64'(n + 1), 64'd10);
        issue8(1'b1, 8'h80, 8'h80);
        wait_done8(9, n);
        issue8(1'b1, 8'hFD, 8'h05);
        wait_done8(9, n);
        issue8(1'b1, 8'h7F, 8'h00);
        wait_done8(9, n);

        // Start while busy is ignored.
        issue8(1'b0, 8'h21, 8'h43);
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(6, n);
        repeat (14) @(negedge clk);

        // Reset during the 4th RUN cycle aborts the operation.
        issue8(1'b0, 8'h5A, 8'h3C);
        repeat (3) @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        q8.delete();
        check("abort_busy8", busy8, 0);
        check("abort_done8", done8, 0);
        check("abort_product8", prod8, 0);
        repeat (15) @(negedge clk);
        issue8(1'b1, 8'h9C, 8'h37);
        wait_done8(9, n);

        for (int i = 0; i < 25; i++) begin
            issue8(1'($urandom), 8'(pick(8)), 8'(pick(8)));
            wait_done8(9, n);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        issue16(1'b0, 16'hFFFF, 16'hFFFF);
        wait_done16(17, n);
        issue16(1'b1, 16'h8000, 16'h0001);
        wait_done16(17, n);
        check("b2b_spacing16", 64'(n + 1), 64'd18);
        for (int i = 0; i < 15; i++) begin
            issue16(1'($urandom), pick(16), pick(16));
            wait_done16(17, n);
        end

        repeat (25) @(negedge clk);
        check("queue8_drained", 64'(q8.size()), 0);
        check("queue16_drained", 64'(q16.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
